meter_credit: RTL and testbench
===============================

// Module: meter_credit
// PURPOSE
//  Holds the parking meter's remaining paid time in seconds and feeds sec_count to time_display.
//  Debounced coin buttons add fixed credit. The 1 Hz tick counts the credit down while a car is parked.
//  A car leaving forfeits all remaining credit.
//  Status flags (expired, low_time) drive the blink and lamp logic in display_control.
// PARAMETERS
//  CNT_W      12    width of sec_count
//  MAX_SEC    3599  saturation ceiling in seconds (59:59)
//  ADD0       60    seconds added by add_btn[0]
//  ADD1       120   seconds added by add_btn[1]
//  ADD2       180   seconds added by add_btn[2]
//  ADD3       300   seconds added by add_btn[3]
//  LOW_THRESH 15    low_time asserts when 0 < sec_count < LOW_THRESH
// PORTS
//  clk        in   1      system clock; all logic on its rising edge
//  rst        in   1      asynchronous, active-low reset
//  tick_1hz   in   1      one-clk-wide pulse per second, synchronous to clk
//  add_btn    in   4      debounced button levels; an action fires on each rising edge
//  parked     in   1      sensor level: car present
//  sec_count  out  CNT_W  remaining seconds, registered
//  expired    out  1      sec_count == 0, registered
//  low_time   out  1      0 < sec_count < LOW_THRESH, registered
//  add_ack    out  1      one-cycle pulse when a credit add is accepted
// BEHAVIOUR
//  Reset
//   - rst low asynchronously clears: sec_count=0, expired=1, low_time=0, add_ack=0.
//   - Also clears the edge-detect history registers (btn_q=0, parked_q=0) and sets state=EMPTY.
//   - Buttons held through reset release do not fire: btn_q loads the live level on the first clock after reset.
//  Edge detect
//   - rise[i] = add_btn[i] & ~btn_q[i].
//   - leave = ~parked & parked_q.
//  Credit add
//   - If several rise bits are set in one cycle, only the highest index counts (ADD3 > ADD2 > ADD1 > ADD0).
//   - One add at most per cycle; add_ack pulses that cycle+1.
//  Latency
//   - An edge sampled at clk edge N makes sec_count, the flags and add_ack valid after edge N+1.
//  Arithmetic
//   - Compute in CNT_W+1 bits:
//     next = min( sec_count - dec + add_amt, MAX_SEC )
//   - dec = tick_1hz & parked & (sec_count != 0).
//   - add_amt = 0 when there is no rise.
//   - Never wraps, never goes below 0.
//   - An add at MAX_SEC is still acknowledged; the count stays at MAX_SEC.
//  Leave
//   - leave has priority over everything: next = 0 and add_ack = 0, even if a tick or rise arrives the same cycle.
//  Parking state
//   - When parked is low and there is no leave, credit holds; ticks are ignored.
//   - Adds are still accepted (prepay).
//  FSM (state is registered alongside sec_count; the flags decode next state)
//   - EMPTY   (count 0):                -> RUNNING on an add giving >= LOW_THRESH; -> LOW on an add giving < LOW_THRESH.
//   - RUNNING (count >= LOW_THRESH):    -> LOW when next < LOW_THRESH; -> EMPTY on leave.
//   - LOW     (0 < count < LOW_THRESH): -> EMPTY when next == 0; -> RUNNING on an add lifting next >= LOW_THRESH.
//   - expired = (state == EMPTY); low_time = (state == LOW).
//  Mid-operation reset: an asynchronous rst low at any cycle forces the reset values immediately, with no clk needed.
// TESTING
//  1. rst low, then release; add_btn held at 4'b0001 -> no add fires, sec_count=0, expired=1.
//  2. parked=1, rise on add_btn[0] -> sec_count=60 one cycle later, add_ack=1 for 1 cycle; after 46 ticks -> 14, low_time=1.
//  3. Same cycle: rise on add_btn[1] and add_btn[3] with a tick, starting at 10 -> sec_count=309, state RUNNING, low_time=0.
//  4. sec_count=3500, rise on add_btn[3] -> sec_count=3599, add_ack=1; a further add keeps 3599.
//  5. sec_count=1, parked=1, tick -> 0, expired=1; further ticks keep 0 (no wrap to 4095).
//  6. sec_count=200, parked 1->0 with a simultaneous rise on add_btn[2] -> sec_count=0, expired=1, add_ack=0.

Source files
------------

// File: rtl/meter_credit.sv
// rtl/meter_credit.sv - parking meter credit counter with coin adds, 1 Hz countdown and status flags
// Holds remaining paid seconds; coin edges add credit, ticks count down while parked, leaving clears.
module meter_credit #(
    parameter int CNT_W      = 12,
    parameter int MAX_SEC    = 3599,
    parameter int ADD0       = 60,
    parameter int ADD1       = 120,
    parameter int ADD2       = 180,
    parameter int ADD3       = 300,
    parameter int LOW_THRESH = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_1hz,
    input  logic [3:0]       add_btn,
    input  logic             parked,
    output logic [CNT_W-1:0] sec_count,
    output logic             expired,
    output logic             low_time,
    output logic             add_ack
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_RUNNING = 2'd1,
        ST_LOW     = 2'd2
    } state_t;

    localparam logic [CNT_W:0]   L_ADD0   = (CNT_W+1)'(ADD0);
    localparam logic [CNT_W:0]   L_ADD1   = (CNT_W+1)'(ADD1);
    localparam logic [CNT_W:0]   L_ADD2   = (CNT_W+1)'(ADD2);
    localparam logic [CNT_W:0]   L_ADD3   = (CNT_W+1)'(ADD3);
    localparam logic [CNT_W:0]   L_MAX_W  = (CNT_W+1)'(MAX_SEC);
    localparam logic [CNT_W-1:0] L_MAX    = CNT_W'(MAX_SEC);
    localparam logic [CNT_W-1:0] L_THRESH = CNT_W'(LOW_THRESH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_btn_q;
    logic             r_parked_q;
    logic             r_armed;
    logic [CNT_W-1:0] r_sec;
    logic             r_expired;
    logic             r_low;
    logic             r_ack;

    logic [3:0]       w_rise;
    logic             w_leave;
    logic             w_dec;
    logic             w_add_any;
    logic [CNT_W:0]   w_add_amt;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_sec_nxt;
    logic             w_expired_nxt;
    logic             w_low_nxt;
    logic             w_ack_nxt;

    // r_armed masks the first clock after reset so buttons held through release do not fire
    assign w_rise    = r_armed ? (add_btn & ~r_btn_q) : 4'b0000;
    assign w_leave   = ~parked & r_parked_q;
    assign w_dec     = tick_1hz & parked & (r_sec != '0);
    assign w_add_any = |w_rise;

    always_comb begin
        w_add_amt = '0;
        if (w_rise[3])      w_add_amt = L_ADD3;
        else if (w_rise[2]) w_add_amt = L_ADD2;
        else if (w_rise[1]) w_add_amt = L_ADD1;
        else if (w_rise[0]) w_add_amt = L_ADD0;
    end

    // One spare bit keeps the sum from wrapping before saturation; dec is gated on a non-zero count
    assign w_sum = {1'b0, r_sec} - {{CNT_W{1'b0}}, w_dec} + w_add_amt;

    always_comb begin
        w_sec_nxt = w_sum[CNT_W-1:0];
        if (w_leave)
            w_sec_nxt = '0;
        else if (w_sum > L_MAX_W)
            w_sec_nxt = L_MAX;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_EMPTY;
            r_sec      <= '0;
            r_expired  <= 1'b1;
            r_low      <= 1'b0;
            r_ack      <= 1'b0;
            r_btn_q    <= 4'b0000;
            r_parked_q <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sec      <= w_sec_nxt;
            r_expired  <= w_expired_nxt;
            r_low      <= w_low_nxt;
            r_ack      <= w_ack_nxt;
            r_btn_q    <= add_btn;
            r_parked_q <= parked;
            r_armed    <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_sec_nxt >= L_THRESH)  w_state_nxt = ST_RUNNING;
                else if (w_sec_nxt != '0)   w_state_nxt = ST_LOW;
            end
            ST_RUNNING: begin
                if (w_sec_nxt == '0)        w_state_nxt = ST_EMPTY;
                else if (w_sec_nxt < L_THRESH) w_state_nxt = ST_LOW;
            end
            ST_LOW: begin
                if (w_sec_nxt == '0)        w_state_nxt = ST_EMPTY;
                else if (w_sec_nxt >= L_THRESH) w_state_nxt = ST_RUNNING;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        w_expired_nxt = (w_state_nxt == ST_EMPTY);
        w_low_nxt     = (w_state_nxt == ST_LOW);
        w_ack_nxt     = w_add_any & ~w_leave;
    end

    assign sec_count = r_sec;
    assign expired   = r_expired;
    assign low_time  = r_low;
    assign add_ack   = r_ack;

endmodule

// File: tb/tb_meter_credit.sv
// tb/tb_meter_credit.sv - scoreboard bench for meter_credit
module tb_meter_credit;

    logic        clk;
    logic        rst;
    logic        tick_1hz;
    logic [3:0]  add_btn;
    logic        parked;
    logic [11:0] sec_count;
    logic        expired;
    logic        low_time;
    logic        add_ack;

    meter_credit dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .add_btn   (add_btn),
        .parked    (parked),
        .sec_count (sec_count),
        .expired   (expired),
        .low_time  (low_time),
        .add_ack   (add_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [11:0] e_sec;
        logic        e_expd;
        logic        e_low;
        logic        e_ack;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [11:0] m_sec;
    logic [3:0]  m_btn_q;
    logic        m_pq;
    logic        m_armed;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb.pop_front();
            chk({e.tag, ".sec"}, 32'(sec_count), 32'(e.e_sec));
            chk({e.tag, ".expired"}, 32'(expired), 32'(e.e_expd));
            chk({e.tag, ".low"}, 32'(low_time), 32'(e.e_low));
            chk({e.tag, ".ack"}, 32'(add_ack), 32'(e.e_ack));
        end
    endtask

    task automatic step(input string tag, input logic [3:0] btn, input logic tk, input logic pk);
        exp_t       e;
        logic [3:0] rise;
        logic       lv;
        logic       dec;
        int         amt;
        int         nx;
        rise = m_armed ? (btn & ~m_btn_q) : 4'b0000;
        lv   = ~pk & m_pq;
        dec  = tk & pk & (m_sec != 12'd0);
        amt  = rise[3] ? 300 : rise[2] ? 180 : rise[1] ? 120 : rise[0] ? 60 : 0;
        nx   = int'(m_sec) - int'(dec) + amt;
        if (nx > 3599) nx = 3599;
        if (lv) nx = 0;
        e.tag    = tag;
        e.e_sec  = 12'(nx);
        e.e_expd = (nx == 0);
        e.e_low  = (nx > 0) && (nx < 15);
        e.e_ack  = (rise != 4'b0000) && !lv;
        sb.push_back(e);
        m_sec   = 12'(nx);
        m_btn_q = btn;
        m_pq    = pk;
        m_armed = 1'b1;
        add_btn  = btn;
        tick_1hz = tk;
        parked   = pk;
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic press(input string tag, input logic [3:0] btn, input logic pk);
        step(tag, btn, 1'b0, pk);
        step({tag, "_rel"}, 4'b0000, 1'b0, pk);
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 4'b0000, 1'b1, 1'b1);
    endtask

    task automatic do_reset(input logic [3:0] held);
        add_btn  = held;
        tick_1hz = 1'b0;
        parked   = 1'b0;
        rst      = 1'b0;
        m_sec    = 12'd0;
        m_btn_q  = 4'b0000;
        m_pq     = 1'b0;
        m_armed  = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with a button held through release
        do_reset(4'b0001);
        chk("reset.sec", 32'(sec_count), 32'd0);
        chk("reset.expired", 32'(expired), 32'd1);
        chk("reset.low", 32'(low_time), 32'd0);
        chk("reset.ack", 32'(add_ack), 32'd0);
        step("held_btn", 4'b0001, 1'b0, 1'b0);
        step("held_btn2", 4'b0001, 1'b0, 1'b0);
        chk("held.sec", 32'(sec_count), 32'd0);
        step("held_rel", 4'b0000, 1'b0, 1'b0);

        // 2: add 60 then count down to 14
        step("park", 4'b0000, 1'b0, 1'b1);
        step("add60", 4'b0001, 1'b0, 1'b1);
        chk("add60.sec", 32'(sec_count), 32'd60);
        chk("add60.ack", 32'(add_ack), 32'd1);
        step("add60_rel", 4'b0000, 1'b0, 1'b1);
        chk("add60.ack_drop", 32'(add_ack), 32'd0);
        ticks("tick46", 46);
        chk("t46.sec", 32'(sec_count), 32'd14);
        chk("t46.low", 32'(low_time), 32'd1);
        ticks("tick4", 4);

        // 3: two rises plus tick from 10
        step("multi", 4'b1010, 1'b1, 1'b1);
        chk("multi.sec", 32'(sec_count), 32'd309);
        chk("multi.low", 32'(low_time), 32'd0);
        step("multi_rel", 4'b0000, 1'b0, 1'b1);

        // 4: saturation
        for (int i = 0; i < 10; i++) press("add300", 4'b1000, 1'b1);
        press("add180", 4'b0100, 1'b1);
        press("add60b", 4'b0001, 1'b1);
        ticks("tick49", 49);
        chk("pre_sat.sec", 32'(sec_count), 32'd3500);
        step("sat", 4'b1000, 1'b0, 1'b1);
        chk("sat.sec", 32'(sec_count), 32'd3599);
        chk("sat.ack", 32'(add_ack), 32'd1);
        step("sat_rel", 4'b0000, 1'b0, 1'b1);
        step("sat2", 4'b0010, 1'b0, 1'b1);
        chk("sat2.sec", 32'(sec_count), 32'd3599);
        chk("sat2.ack", 32'(add_ack), 32'd1);
        step("sat2_rel", 4'b0000, 1'b0, 1'b1);

        // prepay while unparked: leave clears, then ticks ignored and add accepted
        step("leave", 4'b0000, 1'b1, 1'b0);
        press("prepay", 4'b0001, 1'b0);
        step("idle_tick", 4'b0000, 1'b1, 1'b0);
        chk("prepay.sec", 32'(sec_count), 32'd60);

        // 5: count to zero without wrap
        step("repark", 4'b0000, 1'b0, 1'b1);
        ticks("tick59", 59);
        chk("one.sec", 32'(sec_count), 32'd1);
        ticks("tick_zero", 1);
        chk("zero.expired", 32'(expired), 32'd1);
        ticks("tick_hold", 3);
        chk("nowrap.sec", 32'(sec_count), 32'd0);

        // 6: leave beats a same-cycle add
        press("add180c", 4'b0100, 1'b1);
        press("add60c", 4'b0001, 1'b1);
        ticks("tick40", 40);
        chk("pre_leave.sec", 32'(sec_count), 32'd200);
        step("leave_add", 4'b0100, 1'b0, 1'b0);
        chk("leave.sec", 32'(sec_count), 32'd0);
        chk("leave.ack", 32'(add_ack), 32'd0);
        step("leave_rel", 4'b0000, 1'b0, 1'b0);

        // mid-operation asynchronous reset, no clock edge needed
        step("repark2", 4'b0000, 1'b0, 1'b1);
        press("add120", 4'b0010, 1'b1);
        step("ack_pending", 4'b1000, 1'b0, 1'b1);
        rst = 1'b0;
        #2;
        chk("async.sec", 32'(sec_count), 32'd0);
        chk("async.expired", 32'(expired), 32'd1);
        chk("async.ack", 32'(add_ack), 32'd0);
        do_reset(4'b0000);
        step("post_reset", 4'b0000, 1'b0, 1'b0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
